// File: rtl/tx_frontend_lite.sv
// TX analog frontend correction: IQ mapping, IQ imbalance pre-compensation, DC offset, fs/4 up-conversion.
// Define TX_FRONTEND_LITE_IQ_COMP_EN to build the IQ imbalance multipliers; otherwise stage 2 is a plain register.
module tx_frontend_lite #(
   parameter logic [7:0] SR_MAG_CORRECTION = 8'd0,
   parameter logic [7:0] SR_PHASE_CORRECTION = 8'd1,
   parameter logic [7:0] SR_OFFSET_I = 8'd2,
   parameter logic [7:0] SR_OFFSET_Q = 8'd3,
   parameter logic [7:0] SR_IQ_MAPPING = 8'd4,
   parameter logic [7:0] SR_HET_PHASE_INCR = 8'd5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               sync_in,
   input  logic               set_stb,
   input  logic [7:0]         set_addr,
   input  logic [31:0]        set_data,
   input  logic               tx_stb,
   input  logic signed [15:0] tx_i,
   input  logic signed [15:0] tx_q,
   output logic               dac_stb,
   output logic signed [15:0] dac_i,
   output logic signed [15:0] dac_q
);

   function automatic logic signed [15:0] sat16(input logic signed [35:0] v);
      if (v > 36'sd32767) begin
         return 16'sh7fff;
      end else if (v < -36'sd32768) begin
         return 16'sh8000;
      end else begin
         return v[15:0];
      end
   endfunction

   function automatic logic signed [15:0] neg16(input logic signed [15:0] v);
      return (v == 16'sh8000) ? 16'sh7fff : -v;
   endfunction

`ifdef TX_FRONTEND_LITE_IQ_COMP_EN
   logic signed [17:0] mag_r;
   logic signed [17:0] phase_r;
`endif
   logic signed [15:0] off_i_r;
   logic signed [15:0] off_q_r;
   logic [7:0]         map_r;
   logic               het_dir_r;

   logic               s1_vld_r, s2_vld_r, s3_vld_r;
   logic signed [15:0] s1_i_r, s1_q_r, s2_i_r, s2_q_r, s3_i_r, s3_q_r;
   logic signed [15:0] s1_i_s, s1_q_s, s2_i_s, s2_q_s, s3_i_s, s3_q_s, s4_i_s, s4_q_s;
   logic signed [15:0] swp_i_s, swp_q_s, rot_i_s, rot_q_s;
   logic signed [35:0] dc_i_s, dc_q_s;
   logic [1:0]         p_r, p_eff_s, p_next_s;
   logic               byp_s, upc_s, real_s;
   logic               unused_s;

   assign byp_s  = map_r[7];
   assign upc_s  = map_r[4] & ~map_r[7];
   assign real_s = map_r[1] & ~map_r[7];
   assign unused_s = ^{set_data[31:16], map_r[6:5]};

   // Settings bus register file; unmatched addresses leave every register untouched
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
`ifdef TX_FRONTEND_LITE_IQ_COMP_EN
         mag_r     <= 18'sd0;
         phase_r   <= 18'sd0;
`endif
         off_i_r   <= 16'sd0;
         off_q_r   <= 16'sd0;
         map_r     <= 8'd0;
         het_dir_r <= 1'b0;
      end else if (set_stb) begin
         case (set_addr)
`ifdef TX_FRONTEND_LITE_IQ_COMP_EN
            SR_MAG_CORRECTION:   mag_r     <= set_data[17:0];
            SR_PHASE_CORRECTION: phase_r   <= set_data[17:0];
`endif
            SR_OFFSET_I:         off_i_r   <= set_data[15:0];
            SR_OFFSET_Q:         off_q_r   <= set_data[15:0];
            SR_IQ_MAPPING:       map_r     <= set_data[7:0];
            SR_HET_PHASE_INCR:   het_dir_r <= set_data[0];
            default:             het_dir_r <= het_dir_r;
         endcase
      end
   end

   // Stage 1: swap first, then saturating inversion
   always_comb begin
      swp_i_s = map_r[0] ? tx_q : tx_i;
      swp_q_s = map_r[0] ? tx_i : tx_q;
      if (byp_s) begin
         s1_i_s = tx_i;
         s1_q_s = tx_q;
      end else begin
         s1_i_s = map_r[3] ? neg16(swp_i_s) : swp_i_s;
         s1_q_s = map_r[2] ? neg16(swp_q_s) : swp_q_s;
      end
   end

`ifdef TX_FRONTEND_LITE_IQ_COMP_EN
   logic signed [33:0] prod_i_s, prod_q_s;
   logic signed [35:0] cmp_i_s, cmp_q_s;

   // Stage 2: both corrections are driven by I1 (Q gets the phase cross-term)
   always_comb begin
      prod_i_s = 34'(mag_r) * 34'(s1_i_r);
      prod_q_s = 34'(phase_r) * 34'(s1_i_r);
      cmp_i_s  = 36'(s1_i_r) + 36'(prod_i_s >>> 5'd17);
      cmp_q_s  = 36'(s1_q_r) + 36'(prod_q_s >>> 5'd17);
      if (byp_s) begin
         s2_i_s = s1_i_r;
         s2_q_s = s1_q_r;
      end else begin
         s2_i_s = sat16(cmp_i_s);
         s2_q_s = sat16(cmp_q_s);
      end
   end
`else
   assign s2_i_s = s1_i_r;
   assign s2_q_s = s1_q_r;
`endif

   // Stage 3: saturating DC offset
   always_comb begin
      dc_i_s = 36'(s2_i_r) + 36'(off_i_r);
      dc_q_s = 36'(s2_q_r) + 36'(off_q_r);
      if (byp_s) begin
         s3_i_s = s2_i_r;
         s3_q_s = s2_q_r;
      end else begin
         s3_i_s = sat16(dc_i_s);
         s3_q_s = sat16(dc_q_s);
      end
   end

   // Stage 4: fs/4 rotation; sync_in zeroes the phase for the sample in this stage
   always_comb begin
      p_eff_s = sync_in ? 2'd0 : p_r;
      if (s3_vld_r && upc_s) begin
         p_next_s = p_eff_s + (het_dir_r ? 2'd3 : 2'd1);
      end else begin
         p_next_s = p_eff_s;
      end
      case (p_eff_s)
         2'd0: begin rot_i_s = s3_i_r;        rot_q_s = s3_q_r;        end
         2'd1: begin rot_i_s = neg16(s3_q_r); rot_q_s = s3_i_r;        end
         2'd2: begin rot_i_s = neg16(s3_i_r); rot_q_s = neg16(s3_q_r); end
         2'd3: begin rot_i_s = s3_q_r;        rot_q_s = neg16(s3_i_r); end
         default: begin rot_i_s = s3_i_r;     rot_q_s = s3_q_r;        end
      endcase
      if (upc_s) begin
         s4_i_s = rot_i_s;
         s4_q_s = rot_q_s;
      end else begin
         s4_i_s = s3_i_r;
         s4_q_s = s3_q_r;
      end
      if (real_s) begin
         s4_q_s = 16'sd0;
      end else begin
         s4_q_s = s4_q_s;
      end
   end

   // Pipeline: valid bits shift every cycle, data only moves with its valid bit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld_r <= 1'b0;
         s2_vld_r <= 1'b0;
         s3_vld_r <= 1'b0;
         dac_stb  <= 1'b0;
         s1_i_r   <= 16'sd0;
         s1_q_r   <= 16'sd0;
         s2_i_r   <= 16'sd0;
         s2_q_r   <= 16'sd0;
         s3_i_r   <= 16'sd0;
         s3_q_r   <= 16'sd0;
         dac_i    <= 16'sd0;
         dac_q    <= 16'sd0;
         p_r      <= 2'd0;
      end else begin
         s1_vld_r <= tx_stb;
         s2_vld_r <= s1_vld_r;
         s3_vld_r <= s2_vld_r;
         dac_stb  <= s3_vld_r;
         p_r      <= p_next_s;
         if (tx_stb) begin
            s1_i_r <= s1_i_s;
            s1_q_r <= s1_q_s;
         end
         if (s1_vld_r) begin
            s2_i_r <= s2_i_s;
            s2_q_r <= s2_q_s;
         end
         if (s2_vld_r) begin
            s3_i_r <= s3_i_s;
            s3_q_r <= s3_q_s;
         end
         if (s3_vld_r) begin
            dac_i <= s4_i_s;
            dac_q <= s4_q_s;
         end
      end
   end

endmodule

// File: tb/tb_tx_frontend_lite.sv
// Directed bench for tx_frontend_lite: expected samples come from an integer reference model
// and are queued at drive time, then popped whenever dac_stb is seen.
module tb_tx_frontend_lite;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sync_in = 1'b0;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = 8'd0;
   logic [31:0] set_data = 32'd0;
   logic        tx_stb = 1'b0;
   logic [15:0] tx_i = 16'd0;
   logic [15:0] tx_q = 16'd0;
   logic        dac_stb;
   logic [15:0] dac_i;
   logic [15:0] dac_q;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];
   logic [2:0]  hist = 3'd0;
   logic [2:0]  sync_pipe = 3'd0;
   int sh_mag = 0, sh_ph = 0, sh_oi = 0, sh_oq = 0, sh_map = 0, sh_dir = 0, p_m = 0;

   tx_frontend_lite dut (
      .clk(clk), .reset_n(reset_n), .sync_in(sync_in),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .tx_stb(tx_stb), .tx_i(tx_i), .tx_q(tx_q),
      .dac_stb(dac_stb), .dac_i(dac_i), .dac_q(dac_q)
   );

   always #5 clk = ~clk;

   function automatic int sat(input longint v);
      if (v > 32767) return 32767;
      else if (v < -32768) return -32768;
      else return int'(v);
   endfunction

   function automatic int neg(input int v);
      return sat(-longint'(v));
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic model(input int i, input int q, input logic sy, output int oi, output int oq);
      int a, b;
      if (sy) p_m = 0;
      if (sh_map[7]) begin
         oi = i;
         oq = q;
      end else begin
         a = sh_map[0] ? q : i;
         b = sh_map[0] ? i : q;
         if (sh_map[3]) a = neg(a);
         if (sh_map[2]) b = neg(b);
         b = sat(b + ((longint'(sh_ph) * a) >>> 17));
         a = sat(a + ((longint'(sh_mag) * a) >>> 17));
         a = sat(a + sh_oi);
         b = sat(b + sh_oq);
         if (sh_map[4]) begin
            case (p_m)
               0: begin oi = a; oq = b; end
               1: begin oi = neg(b); oq = a; end
               2: begin oi = neg(a); oq = neg(b); end
               default: begin oi = b; oq = neg(a); end
            endcase
            p_m = (p_m + (sh_dir != 0 ? 3 : 1)) % 4;
         end else begin
            oi = a;
            oq = b;
         end
         if (sh_map[1]) oq = 0;
      end
   endtask

   // One clock: drive, queue the expectation, then check dac_stb and any emerging sample
   task automatic step(input logic stb, input int i, input int q, input logic sy);
      int ei, eq;
      logic [31:0] e;
      tx_stb = stb;
      tx_i = 16'(i);
      tx_q = 16'(q);
      sync_in = sync_pipe[2];
      sync_pipe = {sync_pipe[1:0], sy & stb};
      if (stb) begin
         model(i, q, sy, ei, eq);
         exp_q.push_back({ei[15:0], eq[15:0]});
      end
      @(posedge clk);
      #1;
      chk("dac_stb", {31'd0, dac_stb}, {31'd0, hist[2]});
      if (dac_stb) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_sample", {dac_i, dac_q}, 32'hxxxx_xxxx);
         end else begin
            e = exp_q.pop_front();
            chk("dac_iq", {dac_i, dac_q}, e);
         end
      end
      hist = {hist[1:0], stb};
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0);
   endtask

   task automatic wr(input logic [7:0] a, input int d);
      set_stb = 1'b1;
      set_addr = a;
      set_data = 32'(d);
      step(1'b0, 0, 0, 1'b0);
      set_stb = 1'b0;
   endtask

   // Drain the pipe, then rewrite every setting (plus one stray address that must be ignored)
   task automatic cfg(input int mag, input int ph, input int oi, input int oq, input int mp, input int dir);
      idle(4);
      wr(8'd0, mag);
      wr(8'd1, ph);
      wr(8'd2, oi);
      wr(8'd3, oq);
      wr(8'd4, mp);
      wr(8'd5, dir);
      wr(8'd42, -1);
`ifdef TX_FRONTEND_LITE_IQ_COMP_EN
      sh_mag = mag;
      sh_ph = ph;
`else
      sh_mag = 0;
      sh_ph = 0;
`endif
      sh_oi = oi;
      sh_oq = oq;
      sh_map = mp;
      sh_dir = dir;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stb", {31'd0, dac_stb}, 32'd0);
      chk("rst_i", {16'd0, dac_i}, 32'd0);
      chk("rst_q", {16'd0, dac_q}, 32'd0);
      reset_n = 1'b1;

      // dac_stb follows tx_stb by four clock periods
      step(1'b1, 1000, -2000, 1'b0);
      idle(4);

      cfg(0, 0, 0, 0, 32'h09, 0);
      step(1'b1, -32768, 5, 1'b0);
      step(1'b1, 5, -32768, 1'b0);

      cfg(32'h10000, 0, 0, 0, 0, 0);
      step(1'b1, 8000, 0, 1'b0);
      cfg(-32'h10000, 32'h8000, 0, 0, 0, 0);
      step(1'b1, -7, 100, 1'b0);
      step(1'b1, 8000, -32000, 1'b0);
      step(1'b1, -32768, 32767, 1'b0);

      cfg(0, 0, 30000, -30000, 0, 0);
      step(1'b1, 10000, 0, 1'b0);
      step(1'b1, 0, -10000, 1'b0);

      cfg(0, 0, 0, 0, 32'h02, 0);
      step(1'b1, 123, 456, 1'b0);

      cfg(0, 0, 0, 0, 32'h10, 0);
      for (int k = 0; k < 8; k++) step(1'b1, 100, 0, 1'b0);
      cfg(0, 0, 0, 0, 32'h10, 1);
      for (int k = 0; k < 6; k++) step(1'b1, 100, 0, 1'b0);
      step(1'b1, 100, 0, 1'b1);
      step(1'b1, 100, 0, 1'b0);
      step(1'b1, 100, 0, 1'b0);

      // gaps must be replayed on dac_stb and must not advance the phase
      cfg(0, 0, 0, 0, 32'h10, 0);
      step(1'b1, 100, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b1, 100, 0, 1'b0);
      step(1'b1, 100, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b1, 100, 0, 1'b0);

      cfg(32'h8000, -32'h8000, 1234, -555, 32'h92, 0);
      step(1'b1, -32768, 32767, 1'b0);
      step(1'b1, 4321, -1, 1'b0);
      step(1'b1, 0, -32768, 1'b0);

      cfg(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) step(1'b1, 11 * k, -3 * k, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("midrst_stb", {31'd0, dac_stb}, 32'd0);
      chk("midrst_i", {16'd0, dac_i}, 32'd0);
      chk("midrst_q", {16'd0, dac_q}, 32'd0);
      exp_q.delete();
      hist = 3'd0;
      sync_pipe = 3'd0;
      p_m = 0;
      #2;
      reset_n = 1'b1;
      step(1'b1, -1234, 777, 1'b0);
      idle(5);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
